// File: rtl/fetch_entry_queue_pkg.sv
// Fetch-entry types and the core configuration used by the fetch->decode queue.
// Mirrors the subset of the core's fetch_entry_t and config needed by this block.
package fetch_entry_queue_pkg;

  localparam int unsigned Vlen = 64;

  typedef struct packed {
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: Vlen};

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    cf_t             cf;
    logic [Vlen-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [Vlen-1:0]    address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_queue.sv
// Circular FIFO between the realigner and decode; a push into a full queue is dropped
// and reported as a replay so the frontend re-fetches from that PC.
module fetch_entry_queue
  import fetch_entry_queue_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        instr_valid_i,
  input  fetch_entry_t                fetch_entry_i,
  output logic                        replay_o,
  output logic [CVA6Cfg.VLEN-1:0]     replay_addr_o,
  output fetch_entry_t                fetch_entry_o,
  output logic                        fetch_entry_valid_o,
  input  logic                        fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t          mem_q [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       count_q;

  logic full, empty, push, pop;

  // full/empty come from registered state only, so ready never reaches replay_o.
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign fetch_entry_valid_o = ~empty & ~flush_i;
  assign fetch_entry_o       = mem_q[rd_ptr_q];
  assign count_o             = count_q;

  assign push = instr_valid_i & ~full & ~flush_i;
  assign pop  = fetch_entry_valid_o & fetch_entry_ready_i;

  // A pop in the same cycle does not make room for a push into a full queue.
  assign replay_o      = instr_valid_i & full & ~flush_i;
  assign replay_addr_o = fetch_entry_i.address[CVA6Cfg.VLEN-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= fetch_entry_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: doc/fetch_entry_queue.md
# fetch_entry_queue

Frontend-side producer for the fetch→decode handshake. It buffers realigned instructions (`ariane_pkg::fetch_entry_t`) from the frontend in a circular FIFO and presents them to the decode stage on a valid/ready interface. When a push arrives while the queue is full, it requests a replay from the PC of the dropped instruction. On a flush it discards all buffered entries.

## Interface
Parameters:
- `CVA6Cfg` — default `config_pkg::cva6_cfg_empty` — core configuration; supplies VLEN.
- `DEPTH` — default 4 — number of entries; a power of two, ≥ 2.

Ports:
- `clk_i` — in — 1 — clock.
- `rst_ni` — in — 1 — reset; asynchronous, active-low.
- `flush_i` — in — 1 — controller flush; discards all entries.
- `instr_valid_i` — in — 1 — frontend offers `fetch_entry_i` this cycle.
- `fetch_entry_i` — in — `fetch_entry_t` — instruction, address, branch_predict, ex.
- `replay_o` — out — 1 — the offered entry was dropped because the queue is full.
- `replay_addr_o` — out — VLEN — PC to re-fetch; equals `fetch_entry_i.address`.
- `fetch_entry_o` — out — `fetch_entry_t` — head entry toward decode.
- `fetch_entry_valid_o` — out — 1 — head entry is valid.
- `fetch_entry_ready_i` — in — 1 — decode accepts the head this cycle.
- `count_o` — out — $clog2(DEPTH)+1 — current occupancy.

## Operation
- State:
  - `mem_q[DEPTH]`
  - `rd_ptr_q`, `wr_ptr_q`, each $clog2(DEPTH) bits; both wrap naturally modulo DEPTH.
  - `count_q`, range 0..DEPTH.
- `full = (count_q == DEPTH)` and `empty = (count_q == 0)`. Both are derived from registered state only. There is no combinational path from `fetch_entry_ready_i` to `replay_o`.
- Push:
  - Condition: `instr_valid_i & ~full & ~flush_i`.
  - Action: write `mem_q[wr_ptr_q]`, increment `wr_ptr_q`.
- Pop:
  - Condition: `fetch_entry_valid_o & fetch_entry_ready_i`.
  - Action: increment `rd_ptr_q`.
- Count update: `count_n = count_q + push - pop`. A simultaneous push and pop leaves count unchanged.
- Full push:
  - Condition: `instr_valid_i & full & ~flush_i`.
  - Response: `replay_o=1` and `replay_addr_o=fetch_entry_i.address` in the same cycle (combinational). Nothing is written.
  - A simultaneous pop does not rescue the push.
  - The frontend must squash its in-flight fetches and redirect when it sees `replay_o`.
- Outputs:
  - `fetch_entry_o = mem_q[rd_ptr_q]`.
  - `fetch_entry_valid_o = ~empty & ~flush_i`.
  - `count_o = count_q`.
- Flush:
  - In the flush cycle: no push, no pop, `replay_o=0`, `fetch_entry_valid_o=0`.
  - On the next edge: `rd_ptr`, `wr_ptr` and `count` go to 0.
  - Flush overrides every other event in the same cycle.
- Entry contents pass through untouched. Exceptions in `fetch_entry_i.ex` are queued like normal entries.

## Timing
- Reset values:
  - `count_q=0`, pointers 0, all `mem_q` entries '0.
  - Therefore `fetch_entry_o='0`, `fetch_entry_valid_o=0`, `replay_o=0` (with `instr_valid_i` low), `count_o=0`.
- Latency: an entry pushed at edge N is visible on `fetch_entry_o`/`fetch_entry_valid_o` in cycle N+1. There is no empty-queue bypass.
- Throughput: one push and one pop per cycle, sustained, at any occupancy from 1 to DEPTH-1.
- Valid/ready rules:
  - `fetch_entry_o` is stable while valid is high and ready is low.
  - Valid never drops without a pop or a flush.
- Boundaries:
  - Pop when empty: impossible, since valid is low.
  - Push at DEPTH-1 with no pop: count goes to DEPTH, full from the next cycle.
  - Wrap-around from pointer DEPTH-1 to 0 preserves FIFO order.
  - Reset asserted mid-operation clears all state asynchronously. Outputs take reset values immediately.

## Structure
- No new package content. `fetch_entry_t` already lives in `ariane_pkg`; DEPTH is a local parameter of the instance.
- Pointer width is a localparam `$clog2(DEPTH)`.
- Single flat module with no sub-module. The storage is a simple register array; a generic FIFO would hide the replay/full timing this block must control.

## Test plan
- Reset, then push 3 entries with addresses 0x80000000, 0x80000004, 0x80000008 and ready low:
  - `count_o=3`, `fetch_entry_o.address=0x80000000`, valid=1.
  - Then hold ready=1 for 3 cycles: addresses pop in order, valid=0 afterwards.
- DEPTH=4, fill with 4 entries, then push address 0x80000010 with ready=1 in the same cycle:
  - `replay_o=1`, `replay_addr_o=0x80000010`.
  - After the edge, `count_o=3` and 0x80000010 is never emitted.
- Continuous push and pop for 10 cycles from `count_o=2`:
  - `count_o` stays 2; outputs are in order across pointer wrap (≥ 2 wraps).
- With `count_o=3`, assert `flush_i` together with a push and ready=1:
  - In the flush cycle: valid=0, `replay_o=0`.
  - Next cycle: `count_o=0`, valid=0; the pushed entry is discarded.
- Push an entry with `ex.valid=1` and `ex.cause=1`:
  - It emerges unchanged on `fetch_entry_o` one cycle later.
- Assert `rst_ni` low mid-stream with `count_o=2`:
  - valid=0, `count_o=0` and `fetch_entry_o='0` immediately.
  - After release, the first push appears at the head one cycle later.
